// File: rtl/data_bus_pkg.sv
// Data bus encodings and the load-lane extraction helper shared with the LSU.
package data_bus_pkg;

  localparam logic [1:0] BUS_MODE_IDLE  = 2'b00;
  localparam logic [1:0] BUS_MODE_READ  = 2'b01;
  localparam logic [1:0] BUS_MODE_WRITE = 2'b10;

  localparam logic [1:0] BUS_W_BYTE = 2'b00;
  localparam logic [1:0] BUS_W_HALF = 2'b01;
  localparam logic [1:0] BUS_W_WORD = 2'b10;

  typedef enum logic {ST_IDLE, ST_RESP} mem_state_e;

  // Read-side controls captured at accept, consumed in the response cycle
  typedef struct packed {
    logic [1:0] lo;    // addr[1:0]
    logic [1:0] w;     // request width
    logic       s;     // sign-extend
  } rd_ctl_t;

  // Pick the addressed byte/half out of a RAM word and zero/sign extend it
  function automatic logic [31:0] bus_extract(input logic [31:0] word,
                                              input logic [1:0]  lo,
                                              input logic [1:0]  w,
                                              input logic        s);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*lo +: 8];
    h = lo[1] ? word[31:16] : word[15:0];
    case (w)
      BUS_W_BYTE: return {{24{s & b[7]}}, b};
      BUS_W_HALF: return {{16{s & h[15]}}, h};
      default:    return word;
    endcase
  endfunction

endpackage

// File: rtl/mem_bank.sv
// One data memory slice: WORDS x 32 sync RAM, byte-enabled write, 1-cycle read.
module mem_bank #(
  parameter int WORDS = 512,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  // Byte-lane write port
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  // Registered read; a bank not reading returns 0 so banks can be OR-ed
  always_ff @(posedge clk) begin
    rdata <= (en && !we) ? mem[addr] : 32'd0;
  end

endmodule

// File: rtl/data_memory_banked.sv
// Banked data memory slave: one-wait-state ready, fault decode and fault-address capture.
module data_memory_banked
  import data_bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h3000,
  parameter int          NUM_SLICES  = 2,
  parameter int          SLICE_BYTES = 2048
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_bus_select,
  input  logic [1:0]  data_bus_mode,
  input  logic [1:0]  data_bus_reqw,
  input  logic        data_bus_reqs,
  input  logic [31:0] data_bus_addr,
  input  logic [31:0] data_bus_write,
  output logic [31:0] data_bus_read,
  output logic        data_bus_ready,
  output logic        data_bus_fault,
  output logic [31:0] fault_addr
);

  localparam int SB_LOG = $clog2(SLICE_BYTES);
  localparam int WORDS  = SLICE_BYTES / 4;
  localparam int AW     = (SB_LOG > 2) ? SB_LOG - 2 : 1;
  localparam int SW     = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  // 33-bit end of window so a window ending at 4 GiB does not wrap
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(NUM_SLICES) * 33'(SLICE_BYTES);

  mem_state_e state;
  rd_ctl_t    rd_ctl;
  logic       rd_ok;
  logic       accept, bad, misalign, out_of_range, bank_we;
  logic [31:0] offset, wdata_lanes, rd_or;
  logic [SW-1:0] slice_sel;
  logic [AW-1:0] widx;
  logic [3:0]    be;
  logic [NUM_SLICES-1:0]         bank_en;
  logic [NUM_SLICES-1:0][31:0]   bank_rdata;

  // Reset is folded in so an accept edge that coincides with reset touches no RAM
  assign accept = (state == ST_IDLE) && data_bus_select &&
                  (data_bus_mode != BUS_MODE_IDLE) && !reset;

  assign misalign = ((data_bus_reqw == BUS_W_HALF) && data_bus_addr[0]) ||
                    ((data_bus_reqw == BUS_W_WORD) && (data_bus_addr[1:0] != 2'b00));
  assign out_of_range = ({1'b0, data_bus_addr} < {1'b0, BASE_ADDR}) ||
                        ({1'b0, data_bus_addr} >= LIMIT);
  assign bad = (data_bus_mode == 2'b11) || (data_bus_reqw == 2'b11) ||
               misalign || out_of_range;

  assign offset    = data_bus_addr - BASE_ADDR;
  assign slice_sel = SW'(offset >> SB_LOG);
  assign widx      = AW'((offset >> 2) & 32'(WORDS - 1));
  assign bank_we   = (data_bus_mode == BUS_MODE_WRITE);

  // Replicate right-aligned store data onto every lane and pick byte enables
  always_comb begin
    be          = 4'b1111;
    wdata_lanes = data_bus_write;
    case (data_bus_reqw)
      BUS_W_BYTE: begin
        be          = 4'b0001 << data_bus_addr[1:0];
        wdata_lanes = {4{data_bus_write[7:0]}};
      end
      BUS_W_HALF: begin
        be          = data_bus_addr[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{data_bus_write[15:0]}};
      end
      default: ;
    endcase
  end

  for (genvar gi = 0; gi < NUM_SLICES; gi++) begin : g_bank
    assign bank_en[gi] = accept && !bad && (slice_sel == SW'(gi));
    mem_bank #(.WORDS(WORDS), .AW(AW)) u_bank (
      .clk   (clk),
      .en    (bank_en[gi]),
      .we    (bank_we),
      .be    (be),
      .addr  (widx),
      .wdata (wdata_lanes),
      .rdata (bank_rdata[gi])
    );
  end

  // Unselected banks return 0, so an OR merges slice read data
  always_comb begin
    rd_or = '0;
    for (int i = 0; i < NUM_SLICES; i++) rd_or |= bank_rdata[i];
  end

  assign data_bus_read = rd_ok ? bus_extract(rd_or, rd_ctl.lo, rd_ctl.w, rd_ctl.s) : 32'd0;

  // Handshake FSM with registered ready/fault and sticky fault address
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      data_bus_ready <= 1'b0;
      data_bus_fault <= 1'b0;
      fault_addr     <= 32'd0;
      rd_ok          <= 1'b0;
      rd_ctl         <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          data_bus_ready <= accept;
          data_bus_fault <= accept && bad;
          rd_ok          <= accept && !bad && (data_bus_mode == BUS_MODE_READ);
          if (accept) begin
            state  <= ST_RESP;
            rd_ctl <= '{lo: data_bus_addr[1:0], w: data_bus_reqw, s: data_bus_reqs};
            if (bad) fault_addr <= data_bus_addr;
          end
        end
        default: begin
          state          <= ST_IDLE;
          data_bus_ready <= 1'b0;
          data_bus_fault <= 1'b0;
          rd_ok          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_banked.sv
// Self-checking bench for data_memory_banked: directed cases plus random traffic
// against a byte-addressed reference memory.
module tb_data_memory_banked;

  localparam logic [31:0] BASE = 32'h3000;
  localparam int NS   = 2;
  localparam int SB   = 2048;
  localparam int SPAN = NS * SB;

  logic        clk = 1'b0;
  logic        reset;
  logic        data_bus_select;
  logic [1:0]  data_bus_mode;
  logic [1:0]  data_bus_reqw;
  logic        data_bus_reqs;
  logic [31:0] data_bus_addr;
  logic [31:0] data_bus_write;
  logic [31:0] data_bus_read;
  logic        data_bus_ready;
  logic        data_bus_fault;
  logic [31:0] fault_addr;

  int tests  = 0;
  int failed = 0;
  logic [7:0]  ref_mem [SPAN];
  logic [31:0] exp_fa;

  data_memory_banked #(.BASE_ADDR(BASE), .NUM_SLICES(NS), .SLICE_BYTES(SB)) dut (
    .clk             (clk),
    .reset           (reset),
    .data_bus_select (data_bus_select),
    .data_bus_mode   (data_bus_mode),
    .data_bus_reqw   (data_bus_reqw),
    .data_bus_reqs   (data_bus_reqs),
    .data_bus_addr   (data_bus_addr),
    .data_bus_write  (data_bus_write),
    .data_bus_read   (data_bus_read),
    .data_bus_ready  (data_bus_ready),
    .data_bus_fault  (data_bus_fault),
    .fault_addr      (fault_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: byte-addressed memory, little-endian, faults from the access rules
  function automatic void model(input logic [1:0] mode, input logic [1:0] w, input logic s,
                                input logic [31:0] addr, input logic [31:0] wd,
                                output logic f, output logic [31:0] rd);
    longint a;
    int n, off;
    a  = {32'd0, addr};
    rd = 32'd0;
    n  = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : (w == 2'd2) ? 4 : 0;
    f  = (mode == 2'd3) || (n == 0) || (n > 1 && (a % n) != 0) ||
         (a < longint'(BASE)) || (a >= longint'(BASE) + SPAN);
    if (f) begin
      exp_fa = addr;
      return;
    end
    off = int'(a - longint'(BASE));
    for (int k = 0; k < n; k++) begin
      if (mode == 2'd2) ref_mem[off + k] = wd[8*k +: 8];
      else              rd[8*k +: 8]     = ref_mem[off + k];
    end
    if (mode == 2'd1 && s && n < 4 && rd[8*n-1])
      for (int k = n; k < 4; k++) rd[8*k +: 8] = 8'hFF;
  endfunction

  task automatic drive(input logic [1:0] mode, input logic [1:0] w, input logic s,
                       input logic [31:0] addr, input logic [31:0] wd);
    data_bus_select = 1'b1;
    data_bus_mode   = mode;
    data_bus_reqw   = w;
    data_bus_reqs   = s;
    data_bus_addr   = addr;
    data_bus_write  = wd;
  endtask

  task automatic idle_bus();
    data_bus_select = 1'b0;
    data_bus_mode   = 2'b00;
  endtask

  // One request: checks latency, response data, fault flag and fault address
  task automatic txn(input string tag, input logic [1:0] mode, input logic [1:0] w,
                     input logic s, input logic [31:0] addr, input logic [31:0] wd,
                     output logic [31:0] rd, output logic f);
    logic [31:0] erd;
    logic        ef;
    int          lat;
    model(mode, w, s, addr, wd, ef, erd);
    chk({tag, " idle_ready"}, {31'd0, data_bus_ready}, 32'd0);
    drive(mode, w, s, addr, wd);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (data_bus_ready !== 1'b1 && lat < 4);
    chk({tag, " latency"}, lat, 32'd1);
    chk({tag, " read"},  data_bus_read, erd);
    chk({tag, " fault"}, {31'd0, data_bus_fault}, {31'd0, ef});
    chk({tag, " fault_addr"}, fault_addr, exp_fa);
    rd = data_bus_read;
    f  = data_bus_fault;
    idle_bus();
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] rd;
    logic        f;
    logic [1:0]  m, w;
    logic [31:0] a;

    reset  = 1'b1;
    exp_fa = 32'd0;
    idle_bus();
    data_bus_reqw  = 2'b00;
    data_bus_reqs  = 1'b0;
    data_bus_addr  = 32'd0;
    data_bus_write = 32'd0;
    #12;
    chk("reset read",  data_bus_read, 32'd0);
    chk("reset ready", {31'd0, data_bus_ready}, 32'd0);
    chk("reset fault", {31'd0, data_bus_fault}, 32'd0);
    chk("reset fault_addr", fault_addr, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Give the RAM a known (zero) image
    for (int i = 0; i < SPAN; i += 4) txn("init", 2'd2, 2'd2, 1'b0, BASE + i, 32'd0, rd, f);

    // Word write then word read
    txn("t2 wr", 2'd2, 2'd2, 1'b0, 32'h3004, 32'hDEADBEEF, rd, f);
    txn("t2 rd", 2'd1, 2'd2, 1'b0, 32'h3004, 32'd0, rd, f);
    chk("t2 rd const", rd, 32'hDEADBEEF);

    // Byte store into slice 1, signed/unsigned/word readback
    txn("t3 wr", 2'd2, 2'd0, 1'b0, 32'h3801, 32'h00000080, rd, f);
    txn("t3 rds", 2'd1, 2'd0, 1'b1, 32'h3801, 32'd0, rd, f);
    chk("t3 signed const", rd, 32'hFFFFFF80);
    txn("t3 rdu", 2'd1, 2'd0, 1'b0, 32'h3801, 32'd0, rd, f);
    chk("t3 unsigned const", rd, 32'h00000080);
    txn("t3 rdw", 2'd1, 2'd2, 1'b0, 32'h3800, 32'd0, rd, f);
    chk("t3 word const", rd, 32'h00008000);

    // Misaligned half faults; fault_addr sticks across a good access
    txn("t4 half", 2'd1, 2'd1, 1'b0, 32'h3003, 32'd0, rd, f);
    chk("t4 fault const", {31'd0, f}, 32'd1);
    chk("t4 fa const", fault_addr, 32'h3003);
    txn("t4 good", 2'd1, 2'd2, 1'b0, 32'h3004, 32'd0, rd, f);
    chk("t4 fa sticky", fault_addr, 32'h3003);

    // Reset asserted mid-response clears outputs at once
    drive(2'd1, 2'd2, 1'b0, 32'h3004, 32'd0);
    @(posedge clk); #1;
    chk("t1 pre ready", {31'd0, data_bus_ready}, 32'd1);
    reset = 1'b1;
    #1;
    chk("t1 read",  data_bus_read, 32'd0);
    chk("t1 ready", {31'd0, data_bus_ready}, 32'd0);
    chk("t1 fault", {31'd0, data_bus_fault}, 32'd0);
    chk("t1 fault_addr", fault_addr, 32'd0);
    exp_fa = 32'd0;
    idle_bus();
    #2 reset = 1'b0;
    @(posedge clk); #1;

    // Reset during an accept edge: the write must not land
    reset = 1'b1;
    drive(2'd2, 2'd2, 1'b0, 32'h3008, 32'h12345678);
    @(posedge clk); #1;
    chk("rst-accept ready", {31'd0, data_bus_ready}, 32'd0);
    idle_bus();
    reset = 1'b0;
    @(posedge clk); #1;
    txn("rst-accept rd", 2'd1, 2'd2, 1'b0, 32'h3008, 32'd0, rd, f);
    chk("rst-accept const", rd, 32'd0);

    // Window boundaries
    txn("t5 last", 2'd1, 2'd2, 1'b0, 32'h3FFC, 32'd0, rd, f);
    chk("t5 last fault", {31'd0, f}, 32'd0);
    txn("t5 above", 2'd1, 2'd2, 1'b0, 32'h4000, 32'd0, rd, f);
    chk("t5 above fault", {31'd0, f}, 32'd1);
    txn("t5 below", 2'd1, 2'd2, 1'b0, 32'h2FFC, 32'd0, rd, f);
    chk("t5 below fault", {31'd0, f}, 32'd1);
    txn("t5 top", 2'd1, 2'd2, 1'b0, 32'hFFFFFFFC, 32'd0, rd, f);

    // Back-to-back held requests: second accept two cycles after the first
    model(2'd2, 2'd2, 1'b0, 32'h3000, 32'hA5A51234, f, rd);
    drive(2'd2, 2'd2, 1'b0, 32'h3000, 32'hA5A51234);
    @(posedge clk); #1;
    chk("t6 wr ready", {31'd0, data_bus_ready}, 32'd1);
    drive(2'd1, 2'd2, 1'b0, 32'h3000, 32'd0);
    @(posedge clk); #1;
    chk("t6 gap ready", {31'd0, data_bus_ready}, 32'd0);
    @(posedge clk); #1;
    chk("t6 rd ready", {31'd0, data_bus_ready}, 32'd1);
    chk("t6 rd data", data_bus_read, 32'hA5A51234);
    idle_bus();
    @(posedge clk); #1;

    // Deselected read is ignored
    data_bus_select = 1'b0;
    data_bus_mode   = 2'd1;
    data_bus_addr   = 32'h3000;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("t6 no-select ready", {31'd0, data_bus_ready | data_bus_fault}, 32'd0);
    end
    idle_bus();

    // Random traffic against the reference
    for (int i = 0; i < 400; i++) begin
      m = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(1, 2));
      w = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      case ($urandom_range(0, 9))
        0:       a = BASE - 32'($urandom_range(1, 8));
        1:       a = BASE + SPAN + 32'($urandom_range(0, 8));
        2:       a = $urandom;
        default: a = BASE + 32'($urandom_range(0, SPAN - 1));
      endcase
      if ($urandom_range(0, 4) != 0) begin
        if (w == 2'd1) a[0] = 1'b0;
        if (w == 2'd2) a[1:0] = 2'b00;
      end
      txn("rand", m, w, 1'($urandom_range(0, 1)), a, $urandom, rd, f);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
